// File: rtl/deser_arbiter_if.sv
// Output byte handshake between the arbiter and its consumer.
// The master side holds byte_out/byte_src/byte_valid until byte_accept.
interface deser_arbiter_if;
    logic [7:0] byte_out;
    logic       byte_src;
    logic       byte_valid;
    logic       byte_accept;

    modport master (
        output byte_out,
        output byte_src,
        output byte_valid,
        input  byte_accept
    );

    modport slave (
        input  byte_out,
        input  byte_src,
        input  byte_valid,
        output byte_accept
    );
endinterface

// File: rtl/deser_arbiter.sv
// Round-robin arbiter sharing one serial deserializer between two sources.
// One byte is granted, collected, acked and delivered before the next grant.
module deser_arbiter (
    input  logic       clock_100KHZ,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       data_a,
    input  logic       data_b,
    input  logic       write_a,
    input  logic       write_b,
    output logic       grant_a,
    output logic       grant_b,
    output logic       des_data_in,
    output logic       des_write_in,
    input  logic       des_status,
    input  logic       des_ready,
    input  logic [7:0] des_data,
    output logic       des_ack,
    deser_arbiter_if.master byte_if,
    output logic       drop_a,
    output logic       drop_b,
    output logic [1:0] arb_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        ACK     = 2'b10,
        DELIVER = 2'b11
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       last_src;
    logic       gsrc;
    logic       pick;
    logic       load_grant;
    logic       load_byte;
    logic [3:0] bit_cnt;
    logic [7:0] byte_q;
    logic       src_q;
    logic       valid_q;

    always_comb begin
        state_nx     = state;
        load_grant   = 1'b0;
        load_byte    = 1'b0;
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        des_data_in  = 1'b0;
        des_write_in = 1'b0;
        des_ack      = 1'b0;
        // Contention goes to whichever source did not win last time.
        pick = ~last_src;
        if (req_a && !req_b) begin
            pick = 1'b0;
        end else if (req_b && !req_a) begin
            pick = 1'b1;
        end
        unique case (state)
            IDLE: begin
                if ((req_a || req_b) && !valid_q) begin
                    state_nx   = GRANT;
                    load_grant = 1'b1;
                end
            end
            GRANT: begin
                grant_a      = ~gsrc;
                grant_b      = gsrc;
                des_data_in  = gsrc ? data_b : data_a;
                des_write_in = (gsrc ? write_b : write_a)
                             & des_status;
                if (des_ready) begin
                    load_byte = 1'b1;
                    state_nx  = ACK;
                end
            end
            ACK: begin
                des_ack  = 1'b1;
                state_nx = DELIVER;
            end
            DELIVER: begin
                if (byte_if.byte_accept) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Keep combinational outputs quiet while reset is held.
        if (!reset) begin
            grant_a      = 1'b0;
            grant_b      = 1'b0;
            des_data_in  = 1'b0;
            des_write_in = 1'b0;
            des_ack      = 1'b0;
        end
    end

    always_ff @(posedge clock_100KHZ) begin
        if (!reset) begin
            state    <= IDLE;
            last_src <= 1'b1;
            gsrc     <= 1'b0;
            bit_cnt  <= 4'd0;
            byte_q   <= 8'd0;
            src_q    <= 1'b0;
            valid_q  <= 1'b0;
            drop_a   <= 1'b0;
            drop_b   <= 1'b0;
        end else begin
            state  <= state_nx;
            drop_a <= write_a & ~grant_a;
            drop_b <= write_b & ~grant_b;
            if (load_grant) begin
                last_src <= pick;
                gsrc     <= pick;
                bit_cnt  <= 4'd0;
            end else if (des_write_in) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (load_byte) begin
                byte_q <= des_data;
                src_q  <= gsrc;
            end
            if (state == ACK) begin
                valid_q <= 1'b1;
            end else if (state == DELIVER && byte_if.byte_accept) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign arb_state          = state;
    assign byte_if.byte_out   = byte_q;
    assign byte_if.byte_src   = src_q;
    assign byte_if.byte_valid = valid_q;

endmodule

// File: tb/tb_deser_arbiter.sv
// Directed bench for deser_arbiter with a small behavioural deserializer.
// Covers single source, contention, intruder, backpressure, gating, reset.
module tb_deser_arbiter;

    logic       clock_100KHZ = 1'b0;
    logic       reset;
    logic       req_a, req_b, data_a, data_b, write_a, write_b;
    logic       grant_a, grant_b, des_data_in, des_write_in;
    logic       des_status, des_ready, des_ack;
    logic [7:0] des_data;
    logic       drop_a, drop_b;
    logic [1:0] arb_state;
    logic       status_en;
    logic [7:0] sh;
    int         cnt;
    logic       rdy;
    int         errors = 0;
    int         checks = 0;

    deser_arbiter_if bif ();

    deser_arbiter dut (
        .clock_100KHZ (clock_100KHZ),
        .reset        (reset),
        .req_a        (req_a),
        .req_b        (req_b),
        .data_a       (data_a),
        .data_b       (data_b),
        .write_a      (write_a),
        .write_b      (write_b),
        .grant_a      (grant_a),
        .grant_b      (grant_b),
        .des_data_in  (des_data_in),
        .des_write_in (des_write_in),
        .des_status   (des_status),
        .des_ready    (des_ready),
        .des_data     (des_data),
        .des_ack      (des_ack),
        .byte_if      (bif),
        .drop_a       (drop_a),
        .drop_b       (drop_b),
        .arb_state    (arb_state)
    );

    always #5 clock_100KHZ = ~clock_100KHZ;

    // Deserializer: shifts 8 strobes MSB first, then holds ready until ack.
    assign des_status = status_en & ~rdy;
    assign des_ready  = rdy;
    assign des_data   = sh;

    always @(posedge clock_100KHZ) begin
        if (!reset) begin
            sh  <= 8'd0;
            cnt <= 0;
            rdy <= 1'b0;
        end else if (des_ack) begin
            cnt <= 0;
            rdy <= 1'b0;
        end else if (des_write_in) begin
            sh  <= {sh[6:0], des_data_in};
            cnt <= cnt + 1;
            if (cnt == 7) rdy <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clock_100KHZ);
        #2;
    endtask

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic src, input logic b);
        if (src) begin
            data_b  = b;
            write_b = 1'b1;
        end else begin
            data_a  = b;
            write_a = 1'b1;
        end
        tick();
        write_a = 1'b0;
        write_b = 1'b0;
        data_a  = 1'b0;
        data_b  = 1'b0;
    endtask

    task automatic run_byte(input logic src,
                            input logic [7:0] val,
                            input int intr,
                            input logic accept_now);
        int n;
        n = 0;
        while (arb_state !== 2'b01 && n < 10) begin
            tick();
            n++;
        end
        chk("grant_state", {6'd0, arb_state}, 8'h01);
        chk("grant_ab", {6'd0, grant_b, grant_a},
            src ? 8'h02 : 8'h01);
        for (int i = 7; i >= 0; i--) begin
            if (src) begin
                data_b  = val[i];
                write_b = 1'b1;
                if (i == intr) write_a = 1'b1;
            end else begin
                data_a  = val[i];
                write_a = 1'b1;
                if (i == intr) write_b = 1'b1;
            end
            #1;
            if (i == 7) begin
                chk("fwd_write", {7'd0, des_write_in}, 8'h01);
                chk("fwd_data", {7'd0, des_data_in},
                    {7'd0, val[i]});
            end
            tick();
            write_a = 1'b0;
            write_b = 1'b0;
            data_a  = 1'b0;
            data_b  = 1'b0;
            if (i == intr)
                chk("drop_pulse", {7'd0, src ? drop_a : drop_b}, 8'h01);
            if (intr > 0 && i == intr - 1)
                chk("drop_clear", {7'd0, src ? drop_a : drop_b}, 8'h00);
        end
        n = 0;
        while (arb_state !== 2'b10 && n < 10) begin
            tick();
            n++;
        end
        chk("ack_state", {6'd0, arb_state}, 8'h02);
        chk("ack_pulse", {7'd0, des_ack}, 8'h01);
        chk("ack_nogrant", {6'd0, grant_b, grant_a}, 8'h00);
        chk("byte_out", bif.byte_out, val);
        chk("byte_src", {7'd0, bif.byte_src}, {7'd0, src});
        tick();
        chk("dlv_state", {6'd0, arb_state}, 8'h03);
        chk("dlv_ack_off", {7'd0, des_ack}, 8'h00);
        chk("dlv_valid", {7'd0, bif.byte_valid}, 8'h01);
        if (accept_now) begin
            bif.byte_accept = 1'b1;
            tick();
            bif.byte_accept = 1'b0;
            chk("acc_idle", {6'd0, arb_state}, 8'h00);
            chk("acc_valid", {7'd0, bif.byte_valid}, 8'h00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        data_a = 1'b0;
        data_b = 1'b0;
        write_a = 1'b0;
        write_b = 1'b0;
        status_en = 1'b1;
        bif.byte_accept = 1'b0;
        tick();
        tick();
        chk("rst_state", {6'd0, arb_state}, 8'h00);
        chk("rst_grant", {6'd0, grant_b, grant_a}, 8'h00);
        chk("rst_ack", {7'd0, des_ack}, 8'h00);
        chk("rst_bout", bif.byte_out, 8'h00);
        chk("rst_valid", {7'd0, bif.byte_valid}, 8'h00);
        chk("rst_drop", {6'd0, drop_b, drop_a}, 8'h00);
        chk("rst_last", {7'd0, dut.last_src}, 8'h01);
        chk("rst_cnt", {4'd0, dut.bit_cnt}, 8'h00);
        reset = 1'b1;

        // Single source, request dropped mid-byte.
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        run_byte(1'b0, 8'hA6, -1, 1'b1);

        // Ignored accept and idle drop.
        bif.byte_accept = 1'b1;
        tick();
        bif.byte_accept = 1'b0;
        chk("stray_accept", {6'd0, arb_state}, 8'h00);
        write_a = 1'b1;
        tick();
        write_a = 1'b0;
        chk("idle_drop", {7'd0, drop_a}, 8'h01);
        tick();
        chk("idle_drop_clr", {7'd0, drop_a}, 8'h00);

        // Contention from reset: A, B, A, B.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        run_byte(1'b0, 8'h3C, -1, 1'b1);
        run_byte(1'b1, 8'h5A, -1, 1'b1);
        run_byte(1'b0, 8'hC3, -1, 1'b1);
        run_byte(1'b1, 8'h81, -1, 1'b1);
        req_a = 1'b0;
        req_b = 1'b0;

        // Intruder strobe from B during A's byte.
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        run_byte(1'b0, 8'hE1, 4, 1'b1);

        // Backpressure holds B off.
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        run_byte(1'b0, 8'h96, -1, 1'b0);
        req_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_nogrant", {7'd0, grant_b}, 8'h00);
            chk("bp_hold", bif.byte_out, 8'h96);
        end
        bif.byte_accept = 1'b1;
        tick();
        bif.byte_accept = 1'b0;
        chk("bp_idle", {6'd0, arb_state}, 8'h00);
        chk("bp_idle_g", {7'd0, grant_b}, 8'h00);
        tick();
        chk("bp_grant_b", {7'd0, grant_b}, 8'h01);
        req_b = 1'b0;
        run_byte(1'b1, 8'h7E, -1, 1'b1);

        // Gating while the deserializer is busy.
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        chk("gate_grant", {6'd0, arb_state}, 8'h01);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        chk("gate_cnt2", {4'd0, dut.bit_cnt}, 8'h02);
        status_en = 1'b0;
        data_a = 1'b1;
        write_a = 1'b1;
        #1;
        chk("gate_wr", {7'd0, des_write_in}, 8'h00);
        tick();
        write_a = 1'b0;
        data_a = 1'b0;
        chk("gate_cnt_hold", {4'd0, dut.bit_cnt}, 8'h02);
        chk("gate_nodrop", {7'd0, drop_a}, 8'h00);
        status_en = 1'b1;
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        chk("gate_cnt4", {4'd0, dut.bit_cnt}, 8'h04);

        // Reset mid-byte abandons it.
        reset = 1'b0;
        tick();
        chk("mrst_state", {6'd0, arb_state}, 8'h00);
        chk("mrst_grant", {6'd0, grant_b, grant_a}, 8'h00);
        chk("mrst_des", {6'd0, des_write_in, des_data_in}, 8'h00);
        chk("mrst_ack", {7'd0, des_ack}, 8'h00);
        chk("mrst_bout", bif.byte_out, 8'h00);
        chk("mrst_misc", {5'd0, bif.byte_src, bif.byte_valid,
                          drop_a | drop_b}, 8'h00);
        chk("mrst_cnt", {4'd0, dut.bit_cnt}, 8'h00);
        reset = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        tick();
        chk("mrst_first_a", {6'd0, grant_b, grant_a}, 8'h01);
        req_a = 1'b0;
        req_b = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/deser_arbiter.md
DESER_ARBITER -- requirements
Module: deser_arbiter

Interface
REQ-001 SHALL have ports: clock_100KHZ  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-low (0 = reset, sampled on clock_100KHZ edge).
REQ-003 SHALL have: req_a, req_b  in  1 each  source wants to send one byte.
REQ-004 SHALL have: data_a, data_b  in  1 each  serial bit, MSB first; write_a, write_b  in  1 each  bit strobe.
REQ-005 SHALL have: grant_a, grant_b  out  1 each  source currently owns the deserializer.
REQ-006 SHALL have: des_data_in, des_write_in  out  1 each  bit and strobe to deserializer.
REQ-007 SHALL have: des_status  in  1  deserializer accepting bits; des_ready  in  1  byte complete; des_data  in  8  assembled byte.
REQ-008 SHALL have: des_ack  out  1  byte consumed, returns deserializer to receive.
REQ-009 SHALL have: byte_out  out  8; byte_src  out  1 (0=A, 1=B); byte_valid  out  1; byte_accept  in  1  consumer handshake.
REQ-010 SHALL have: drop_a, drop_b  out  1 each  one-cycle pulse, strobe from non-granted source discarded; arb_state  out  2  current state.

Function
REQ-011 SHALL implement states IDLE=00, GRANT=01, ACK=10, DELIVER=11, driven onto arb_state.
REQ-012 IDLE: if no req, stay; if exactly one req, grant it; if both, grant source != last_src; go GRANT next cycle.
REQ-013 last_src SHALL update to granted source on GRANT entry, giving strict round-robin on contention.
REQ-014 GRANT: grant_x=1 for granted source only; des_data_in = data_x combinationally; des_write_in = write_x AND des_status.
REQ-015 Strobes arriving while des_status=0 SHALL be discarded, not buffered.
REQ-016 bit_cnt (4 bits) SHALL count forwarded strobes in GRANT; cleared on GRANT entry.
REQ-017 Deassertion of req_x mid-byte SHALL be ignored; grant held until des_ready.
REQ-018 GRANT with des_ready=1: register byte_out<=des_data, byte_src<=granted source, drop grant, go ACK.
REQ-019 ACK: des_ack=1 for exactly one cycle; go DELIVER; byte_valid asserted from DELIVER entry.
REQ-020 DELIVER: hold byte_out/byte_src/byte_valid stable until byte_accept=1; on that edge clear byte_valid, go IDLE.
REQ-021 No new grant SHALL issue while byte_valid=1 (single-byte output buffer).
REQ-022 write_x from source not granted (any state) SHALL pulse drop_x one cycle after the strobe; never forwarded.
REQ-023 des_write_in and des_data_in SHALL be 0 outside GRANT.
REQ-024 byte_accept while byte_valid=0 SHALL be ignored.
REQ-025 Arrival of req in the same cycle as byte_accept SHALL be arbitrated in the following IDLE cycle (min 1 idle cycle between bytes).

Reset
REQ-026 reset=0 SHALL force arb_state=IDLE, last_src=1 (A wins first contention), bit_cnt=0.
REQ-027 reset=0 SHALL drive 0 on grant_a, grant_b, des_write_in, des_data_in, des_ack, byte_out, byte_src, byte_valid, drop_a, drop_b.
REQ-028 reset=0 mid-byte or mid-DELIVER SHALL abandon the byte without ack; system reset of deserializer is external.

Verification
REQ-029 Single source: req_a=1, 8 strobes 1,0,1,0,0,1,1,0 -> byte_out=0xA6, byte_src=0, byte_valid until byte_accept, des_ack one cycle.
REQ-030 Contention: req_a=req_b=1 from reset -> A granted first, then B; alternate thereafter over 4 bytes A,B,A,B.
REQ-031 Intruder: write_b pulsed while A granted -> drop_b one-cycle pulse, byte from A unaffected.
REQ-032 Backpressure: byte_accept held 0 for 20 cycles with req_b=1 -> no grant_b, byte_out stable, grant_b after accept plus one cycle.
REQ-033 Gating: write_a pulsed while des_status=0 -> des_write_in stays 0, bit_cnt unchanged.
REQ-034 Reset mid-byte after 4 bits -> next cycle all outputs 0, arb_state=00, next contention grants A.
